nv_nvdla_cdma_wt_arb_n: RTL
===========================

Name: nv_nvdla_cdma_wt_arb_n

Overview:
- Parametrised N-way arbiter for the CDMA weight-fetch path.
- Supports strict priority (mode 0) and weighted round-robin (mode 1).
- Grants are registered and burst-locked: an owner keeps its grant until its final beat.
- Sits between the per-requester weight request queues and the shared DMA read-request port; gnt_busy applies backpressure from that port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WT_WIDTH, 4, width of each per-requester weight field.
- ARB_MODE, 0, arbitration mode: 0 = strict priority (lowest index wins), 1 = weighted round-robin.
- ID_WIDTH, $clog2(NUM_REQ), width of gnt_id.

Ports:
- nvdla_core_clk  input  1  core clock; all state on rising edge.
- nvdla_core_rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; must stay high until the requester's last beat is granted.
- req_last  input  NUM_REQ  per-requester flag: the current beat is the final beat of its burst.
- weight  input  NUM_REQ*WT_WIDTH  bursts per round-robin turn, requester i at bits [i*WT_WIDTH +: WT_WIDTH]; value 0 is treated as 1; ignored when ARB_MODE=0.
- gnt_busy  input  1  downstream stall; no beat is accepted while high.
- gnt  output  NUM_REQ  one-hot beat grant, combinational from registered state.
- gnt_id  output  ID_WIDTH  registered index of the current owner.
- gnt_vld  output  1  registered; high while in state OWN.

Behaviour:
- Reset (async, active-high). The following are cleared immediately, including mid-burst; no pending ownership survives reset:
  - state = ARB
  - owner/gnt_id = 0
  - gnt_vld = 0
  - gnt = 0
  - rr_ptr = 0
  - credit = 0
  - mid_burst = 0
- Beat definition: beat = gnt_vld & req[owner] & !gnt_busy.
- gnt = one-hot(owner) when beat is true, else all zeros.
- State ARB:
  - If |req and !gnt_busy, select a winner and move to OWN next cycle.
  - Mode 0 winner: lowest set index.
  - Mode 1 winner: first set index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On entry to OWN: owner = winner; credit = max(weight[winner], 1) in mode 1, or 1 in mode 0; mid_burst = 0.
  - If gnt_busy is high or no request is present, stay in ARB.
- Latency: req rising in ARB with gnt_busy low gives gnt_vld = 1 on the next cycle. The first gnt pulse can appear in that same cycle.
- State OWN, processing on each beat:
  - Beat with req_last[owner] = 0: set mid_burst = 1.
  - Beat with req_last[owner] = 1: clear mid_burst and decrement credit.
  - If the post-decrement credit is 0, release.
- State OWN, boundary without a beat: if mid_burst = 0, credit > 0 and req[owner] = 0, release (owner is idle between bursts).
- Release:
  - Next state = ARB; gnt_vld = 0 next cycle.
  - rr_ptr = (owner + 1) mod NUM_REQ. This applies in both modes; only mode 1 uses rr_ptr.
  - A release always inserts exactly one ARB cycle, so no back-to-back ownership across owners.
- Mode 0: credit is always 1, so the owner releases after every burst; a higher-priority request waits at most one burst.
- Protocol violation: req[owner] dropping while mid_burst = 1 does not release ownership. The arbiter holds until req_last. Assertion: req[owner] must not fall while mid_burst.
- Simultaneous gnt_busy and req_last: the last beat is not accepted and state is unchanged; it completes on the first non-busy cycle.
- Requests from non-owners during OWN are ignored; they are evaluated only in ARB.
- The credit counter is WT_WIDTH bits wide and cannot underflow, because release happens at 0.
- gnt is always one-hot or zero. gnt_id is stable throughout OWN.

Test Plan:
- Reset mid-burst:
  - Stimulus: ARB_MODE=1, owner=2, mid_burst=1; assert nvdla_core_rst asynchronously.
  - Response: gnt=0, gnt_vld=0, gnt_id=0 immediately. After deassert, req=4'b0001 gives gnt_vld=1 with gnt_id=0 on the next edge.
- Strict priority:
  - Stimulus: ARB_MODE=0, NUM_REQ=4, req=4'b1010, each burst 2 beats (last on the 2nd).
  - Response: owner 1 is granted for 2 beats, then 1 ARB cycle, then owner 3 for 2 beats. With req[1] re-raised during owner 3's burst, owner 1 wins the next ARB.
- Weighted RR:
  - Stimulus: ARB_MODE=1, weight={4'd0,4'd1,4'd3,4'd2}, all req high, single-beat bursts.
  - Response: grant order 0,0,1,1,1,2,3,0,0,… (weight 0 treated as 1); each owner change shows 1 idle cycle.
- Early release:
  - Stimulus: ARB_MODE=1, weight[0]=3; requester 0 drops req after its first burst while req[1] is high.
  - Response: release at the boundary with rr_ptr=1; owner 1 is granted 2 cycles after req[0] falls.
- Backpressure:
  - Stimulus: owner 0, gnt_busy high for 3 cycles, including the cycle presenting req_last.
  - Response: gnt=0 during busy; ownership is kept and the last beat is accepted on the first non-busy cycle. gnt_busy high in ARB blocks any new grant.
- Wrap-around:
  - Stimulus: ARB_MODE=1, NUM_REQ=4, owner 3 releases, req=4'b0101.
  - Response: rr_ptr wraps to 0, so requester 0 is granted before requester 2.

Source files
------------

// File: rtl/nv_nvdla_cdma_wt_arb_n.sv
// nv_nvdla_cdma_wt_arb_n
// N-way arbiter for the CDMA weight-fetch path. It supports strict priority
// (ARB_MODE=0, lowest index wins) and weighted round-robin (ARB_MODE=1).
// Ownership is registered and locked for a whole burst.
//
// Handshake: a beat is transferred in a cycle when gnt_vld is high, the
// owner's req is high and gnt_busy is low. gnt shows one-hot(owner) only in
// such a cycle. A requester holds req until its req_last beat is granted.
module nv_nvdla_cdma_wt_arb_n #(
  parameter int NUM_REQ  = 4,
  parameter int WT_WIDTH = 4,
  parameter int ARB_MODE = 0,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*WT_WIDTH-1:0]  weight,
  input  logic                         gnt_busy,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [ID_WIDTH-1:0]          gnt_id,
  output logic                         gnt_vld
);

  localparam int IW1 = ID_WIDTH + 1;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_OWN = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WT_WIDTH-1:0]   credit_q, credit_d;
  logic                  mid_burst_q, mid_burst_d;

  logic [WT_WIDTH-1:0]   wt_arr [NUM_REQ];
  logic [ID_WIDTH-1:0]   prio_win;
  logic [ID_WIDTH-1:0]   rr_win;
  logic                  rr_found;
  logic [IW1-1:0]        rr_idx;
  logic [ID_WIDTH-1:0]   winner;
  logic [WT_WIDTH-1:0]   win_credit;
  logic                  owner_req;
  logic                  owner_last;
  logic                  beat;
  logic [WT_WIDTH-1:0]   credit_dec;
  logic                  release_own;

  // Split the packed weight bus into one field per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wt
    assign wt_arr[gi] = weight[gi*WT_WIDTH +: WT_WIDTH];
  end

  // Strict priority: lowest set request index wins.
  always_comb begin
    prio_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) prio_win = ID_WIDTH'(i);
    end
  end

  // Round-robin: first set request searching upward from rr_ptr, wrapping.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + IW1'(k);
      if (rr_idx >= IW1'(NUM_REQ)) rr_idx = rr_idx - IW1'(NUM_REQ);
      if (!rr_found && req[rr_idx[ID_WIDTH-1:0]]) begin
        rr_win   = rr_idx[ID_WIDTH-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign winner     = (ARB_MODE == 1) ? rr_win : prio_win;
  // A zero weight still earns one burst; strict priority always gets one.
  assign win_credit = (ARB_MODE == 1) ?
                      ((wt_arr[winner] == '0) ? WT_WIDTH'(1) : wt_arr[winner]) :
                      WT_WIDTH'(1);

  assign owner_req  = req[owner_q];
  assign owner_last = req_last[owner_q];
  assign gnt_vld    = (state_q == ST_OWN);
  assign beat       = gnt_vld & owner_req & ~gnt_busy;
  assign credit_dec = credit_q - WT_WIDTH'(1);
  assign gnt        = beat ? (NUM_REQ'(1) << owner_q) : '0;
  assign gnt_id     = owner_q;

  // Next-state logic: winner selection in ARB, beat/credit bookkeeping in OWN.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    mid_burst_d = mid_burst_q;
    release_own = 1'b0;
    case (state_q)
      ST_ARB: begin
        if ((|req) && !gnt_busy) begin
          state_d     = ST_OWN;
          owner_d     = winner;
          credit_d    = win_credit;
          mid_burst_d = 1'b0;
        end
      end
      ST_OWN: begin
        if (beat) begin
          if (!owner_last) begin
            mid_burst_d = 1'b1;
          end else begin
            mid_burst_d = 1'b0;
            credit_d    = credit_dec;
            if (credit_dec == '0) release_own = 1'b1;
          end
        end else if (!mid_burst_q && (credit_q != '0) && !owner_req) begin
          // Owner went idle between bursts: hand the port back early.
          release_own = 1'b1;
        end
        if (release_own) begin
          state_d  = ST_ARB;
          rr_ptr_d = (owner_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 :
                     owner_q + ID_WIDTH'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State registers; reset drops any ownership immediately.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q     <= ST_ARB;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      mid_burst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      mid_burst_q <= mid_burst_d;
    end
  end

  // The owner must keep requesting until its last beat is accepted.
  a_req_held_mid_burst: assert property (
    @(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    ((state_q == ST_OWN) && mid_burst_q) |-> owner_req
  );

endmodule
